// File: rtl/janken_round_ctrl.sv
// Round sequencer for three-player janken: collects three hands, judges the round,
// holds the result for SHOW_CYCLES cycles and re-arms collection on a draw.
module janken_round_ctrl #(
    parameter int unsigned SHOW_CYCLES = 50_000_000,
    parameter int unsigned MAX_AIKO    = 7
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       start,
    input  logic       gtp_,
    input  logic [1:0] hand_in,
    output logic [5:0] g_data,
    output logic [1:0] cur_player,
    output logic       busy,
    output logic       result_valid,
    output logic [2:0] win_mask,
    output logic       draw,
    output logic       final_draw,
    output logic [2:0] aiko_cnt
);

    localparam int unsigned      CNT_W      = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [2:0]       AIKO_LIMIT = 3'(MAX_AIKO);

    localparam logic [1:0] GU    = 2'b01;
    localparam logic [1:0] CHOKI = 2'b10;
    localparam logic [1:0] PA    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        JUDGE,
        SHOW
    } state_t;

    state_t           state;
    logic             gtp_prev;
    logic [1:0]       idx;
    logic [CNT_W-1:0] show_cnt;

    logic press;
    logic capture;

    assign press   = gtp_prev & ~gtp_;
    assign capture = press && (hand_in != 2'b00);

    // Round judgement, evaluated from the packed hands while in JUDGE.
    logic [1:0] h0, h1, h2;
    logic       has_gu, has_choki, has_pa;
    logic [1:0] win_hand;
    logic       judged_draw;
    logic       judged_final;
    logic [2:0] judged_mask;
    logic [2:0] aiko_next;

    assign h0 = g_data[5:4];
    assign h1 = g_data[3:2];
    assign h2 = g_data[1:0];

    always_comb begin
        has_gu      = (h0 == GU)    || (h1 == GU)    || (h2 == GU);
        has_choki   = (h0 == CHOKI) || (h1 == CHOKI) || (h2 == CHOKI);
        has_pa      = (h0 == PA)    || (h1 == PA)    || (h2 == PA);
        judged_draw = 1'b1;
        win_hand    = 2'b00;
        case ({has_gu, has_choki, has_pa})
            3'b110: begin judged_draw = 1'b0; win_hand = GU;    end
            3'b011: begin judged_draw = 1'b0; win_hand = CHOKI; end
            3'b101: begin judged_draw = 1'b0; win_hand = PA;    end
            default: ;
        endcase
        judged_mask  = {h2 == win_hand, h1 == win_hand, h0 == win_hand} & {3{~judged_draw}};
        aiko_next    = (aiko_cnt < AIKO_LIMIT) ? aiko_cnt + 3'd1 : aiko_cnt;
        judged_final = judged_draw && (aiko_next == AIKO_LIMIT);
    end

    // NOTE: every register, including the SHOW counter, gets an explicit reset value so
    // the block leaves reset in a known IDLE state regardless of what was in flight.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state        <= IDLE;
            gtp_prev     <= 1'b1;
            idx          <= 2'd0;
            show_cnt     <= '0;
            g_data       <= 6'd0;
            cur_player   <= 2'd3;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            win_mask     <= 3'd0;
            draw         <= 1'b0;
            final_draw   <= 1'b0;
            aiko_cnt     <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // values held at the start of the cycle.
            gtp_prev <= gtp_;
            case (state)
                IDLE: begin
                    if (start) begin
                        g_data     <= 6'd0;
                        aiko_cnt   <= 3'd0;
                        win_mask   <= 3'd0;
                        draw       <= 1'b0;
                        final_draw <= 1'b0;
                        idx        <= 2'd0;
                        cur_player <= 2'd0;
                        busy       <= 1'b1;
                        state      <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (capture) begin
                        g_data <= {g_data[3:0], hand_in};
                        if (idx == 2'd2) begin
                            idx        <= 2'd0;
                            cur_player <= 2'd3;
                            state      <= JUDGE;
                        end else begin
                            idx        <= idx + 2'd1;
                            cur_player <= idx + 2'd1;
                        end
                    end
                end

                JUDGE: begin
                    win_mask     <= judged_mask;
                    draw         <= judged_draw;
                    final_draw   <= judged_final;
                    if (judged_draw) begin
                        aiko_cnt <= aiko_next;
                    end
                    show_cnt     <= SHOW_LOAD;
                    result_valid <= 1'b1;
                    state        <= SHOW;
                end

                SHOW: begin
                    if (show_cnt == '0) begin
                        result_valid <= 1'b0;
                        if (draw && !final_draw) begin
                            // Aiko: replay the round, keeping the draw count.
                            idx        <= 2'd0;
                            cur_player <= 2'd0;
                            g_data     <= 6'd0;
                            win_mask   <= 3'd0;
                            draw       <= 1'b0;
                            final_draw <= 1'b0;
                            state      <= COLLECT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        show_cnt <= show_cnt - CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
